// File: rtl/fdc_pkg.sv
// Shared types and defaults for the synchronous multi-channel FDC.
package fdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } fdc_state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned REF_N_DEF       = 8;
  localparam int unsigned PTAT_N_DEF      = 16;
  localparam int unsigned N_CH_DEF        = 2;

  // Never build a synchronizer shorter than the safe minimum.
  function automatic int unsigned clamp_stages(input int unsigned n);
    return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Synchronizes one asynchronous oscillator into the clk domain and emits a
// one-cycle pulse per rising edge (STAGES+1 cycles after the input edge).
module osc_edge_sync
  import fdc_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic osc,
  output logic pulse
);

  localparam int unsigned N = clamp_stages(STAGES);

  logic [N-1:0] sync;
  logic         prev;

  // Flop chain, previous-level register and registered rise detector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[N-2:0], osc};
      prev  <= sync[N-1];
      pulse <= sync[N-1] & ~prev;
    end
  end

endmodule

// File: rtl/fdc_sync_multi.sv
// Multi-channel frequency-to-digital converter: counts sensor-oscillator
// edges over ref_len FREF periods, single-shot or gapless continuous.
module fdc_sync_multi
  import fdc_pkg::*;
#(
  parameter int unsigned REF_N       = REF_N_DEF,
  parameter int unsigned PTAT_N      = PTAT_N_DEF,
  parameter int unsigned N_CH        = N_CH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [REF_N-1:0]         ref_len,
  input  logic                     fref,
  input  logic [N_CH-1:0]          fptat,
  output logic [N_CH*PTAT_N-1:0]   data,
  output logic [N_CH-1:0]          ovf,
  output logic                     valid,
  output logic                     busy
);

  localparam logic [REF_N-1:0]  REF_ONE  = REF_N'(1);
  localparam logic [PTAT_N-1:0] PTAT_ONE = PTAT_N'(1);

  fdc_state_e        state, state_n;
  logic              fref_p;
  logic [N_CH-1:0]   ptat_p;
  logic [REF_N-1:0]  ref_len_q;
  logic [REF_N-1:0]  ref_len_eff;
  logic [REF_N-1:0]  ref_cnt;
  logic [PTAT_N-1:0] ptat_cnt [N_CH];
  logic [N_CH-1:0]   ovf_acc;
  logic              win_open;
  logic              win_end;

  osc_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ref (
    .clk   (clk),
    .reset (reset),
    .osc   (fref),
    .pulse (fref_p)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    osc_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ptat (
      .clk   (clk),
      .reset (reset),
      .osc   (fptat[g]),
      .pulse (ptat_p[g])
    );
  end

  assign ref_len_eff = (ref_len == '0) ? REF_ONE : ref_len;
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic plus window open/close strobes for the datapath.
  always_comb begin
    state_n  = state;
    win_open = 1'b0;
    win_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = ARM;
      end
      ARM: begin
        if (fref_p) begin
          win_open = 1'b1;
          state_n  = COUNT;
        end
      end
      COUNT: begin
        if (fref_p && ((ref_cnt + REF_ONE) == ref_len_q)) begin
          win_end = 1'b1;
          if (!mode) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Window counters, saturation tracking and result latch.
  // The terminal cycle both latches the closing window (including any
  // coincident sensor edge) and zeroes the counters, so in continuous mode
  // the terminal FREF edge doubles as the opening edge of the next window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_len_q <= '0;
      ref_cnt   <= '0;
      ovf_acc   <= '0;
      data      <= '0;
      ovf       <= '0;
      valid     <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) ptat_cnt[i] <= '0;
    end else begin
      valid <= 1'b0;
      if ((state == IDLE) && start) ref_len_q <= ref_len_eff;

      if (win_open || win_end) begin
        ref_cnt <= '0;
        ovf_acc <= '0;
        for (int unsigned i = 0; i < N_CH; i++) ptat_cnt[i] <= '0;
        if (win_end) begin
          valid <= 1'b1;
          if (mode) ref_len_q <= ref_len_eff;
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (ptat_p[i] && (ptat_cnt[i] == '1)) begin
              data[i*PTAT_N +: PTAT_N] <= '1;
              ovf[i]                   <= 1'b1;
            end else begin
              data[i*PTAT_N +: PTAT_N] <= ptat_cnt[i] + (ptat_p[i] ? PTAT_ONE : '0);
              ovf[i]                   <= ovf_acc[i];
            end
          end
        end
      end else if (state == COUNT) begin
        if (fref_p) ref_cnt <= ref_cnt + REF_ONE;
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (ptat_p[i]) begin
            if (ptat_cnt[i] == '1) ovf_acc[i] <= 1'b1;
            else                   ptat_cnt[i] <= ptat_cnt[i] + PTAT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: doc/fdc_sync_multi.md
Name: fdc_sync_multi

Overview:
- Synchronous, multi-channel frequency-to-digital converter.
- Sits between the on-chip oscillators (one FREF reference, N_CH PTAT/sensor oscillators) and the register/readout logic. All logic runs on one system clock.
- Counts rising edges of every sensor oscillator over a window of ref_len FREF periods, then latches the results with a valid strobe.
- Adds what earlier FDCs lacked: a programmable window, N_CH channels, single-shot and gapless continuous modes, saturation with overflow flags, and a start/busy handshake.

Parameters:
- REF_N, 8, width of ref_len and of the internal window counter.
- PTAT_N, 16, width of each channel's count.
- N_CH, 2, number of sensor-oscillator channels.
- SYNC_STAGES, 2, synchronizer depth for the asynchronous oscillator inputs (minimum 2).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin conversion; sampled only in IDLE.
- mode  in  1  0 = single-shot, 1 = continuous; sampled at each window end.
- ref_len  in  REF_N  window length in FREF rising edges; 0 is treated as 1; sampled when start is accepted and at each continuous restart.
- fref  in  1  asynchronous reference oscillator.
- fptat  in  N_CH  asynchronous sensor oscillators.
- data  out  N_CH*PTAT_N  latched counts; channel i occupies [i*PTAT_N +: PTAT_N].
- ovf  out  N_CH  per-channel saturation flag, latched together with data.
- valid  out  1  one-cycle pulse when data/ovf update.
- busy  out  1  high in ARM and COUNT.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state, data, ovf, valid, busy, all counters and all sync flops go to 0.
  - Reset takes priority over every other event, including mid-window; any partial window is discarded.
- Input conditioning: each oscillator passes through a SYNC_STAGES flop chain and a rise detector (sync & ~prev). This produces a one-clk pulse per input rising edge.
  - Requirement: f_osc < f_clk/2.
  - Input-edge to pulse latency is SYNC_STAGES+1 clk cycles.
- FSM states: IDLE, ARM, COUNT.
  - IDLE: busy=0. start=1 -> capture ref_len (0 -> 1), go to ARM.
  - ARM: busy=1. Wait for the first fref pulse; this edge opens the window. On that cycle: clear ref_cnt and all ptat_cnt, go to COUNT. fptat pulses arriving in ARM are ignored.
  - COUNT: busy=1.
    - Each fref pulse increments ref_cnt.
    - Each fptat[i] pulse increments ptat_cnt[i], saturating at all-ones. An increment attempted at all-ones sets ovf_acc[i].
    - Terminal cycle: the fref pulse that makes ref_cnt equal ref_len.
- Terminal cycle T, for each channel:
  - data[i] <= saturating(ptat_cnt[i] + fptat_pulse[i]), so an edge coincident with the terminal edge is counted in the closing window.
  - ovf[i] <= ovf_acc[i], or 1 if that last increment saturates.
  - valid <= 1 at T+1 only; data/ovf are stable from T+1 until the next update.
- After terminal cycle T:
  - mode=1: stay in COUNT. Counters, accumulators and ref_cnt restart from 0 and ref_len is re-sampled. The terminal fref edge also opens the next window (gapless; no fptat edge lost or double-counted).
  - mode=0: go to IDLE; busy=0 at T+1.
- start while busy is ignored. A start in the same cycle that COUNT returns to IDLE is also ignored; a new start is needed.
- mode changes mid-window take effect only at the window end.
- Wrap-around: ref_cnt never wraps, because it compares with equality against ref_len ≤ 2^REF_N−1.

Decomposition:
- Shared package fdc_pkg:
  - state enum {IDLE, ARM, COUNT};
  - SYNC_STAGES_MIN = 2;
  - default widths.
- One sub-module, osc_edge_sync: SYNC_STAGES flop chain plus rise detector, active-low synchronous reset. Instantiated N_CH+1 times.

Test Plan (clk 100 MHz; fref 1 MHz; fptat phase offset 100 ns from fref):
- Single-shot: ref_len=4, fptat0 = 4 MHz, fptat1 = 2 MHz, start pulse -> one valid pulse; data ch0 = 16, ch1 = 8, ovf = 00; busy falls on the cycle after the terminal cycle.
- Continuous: mode=1, ref_len=4, fptat0 = 4 MHz -> valid pulses exactly 400 clk apart, each with data = 16 (no gap); drop mode to 0 mid-window -> one more valid pulse, then IDLE.
- Saturation: PTAT_N=4 instance, ref_len=8, fptat0 = 4 MHz (32 edges) -> data ch0 = 15, ovf[0] = 1; next window at 1 MHz gives data = 8, ovf[0] = 0.
- ref_len=0 -> behaves as ref_len=1: fptat0 = 4 MHz gives data = 4.
- Reset (reset=0 for one cycle) mid-COUNT after 2 of 4 ref edges -> all outputs 0, IDLE; no valid pulse until a new start.
- Coincident edges: fptat edge aligned to the terminal fref edge, continuous mode -> that edge is counted in the closing window only; the sum over windows equals the total edges.
